// File: rtl/tmds_channel_encoder_pkg.sv
// Shared definitions for the TMDS channel encoder: control tokens, the q_m word
// type, the period state and a byte popcount.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef logic [8:0] qm_word_t;

    typedef enum logic {
        CTRL  = 1'b0,
        VIDEO = 1'b1
    } period_t;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] count;
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, d[i]};
        end
        return count;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Per-pixel symbol bus between the pixel source and one TMDS channel encoder.
interface tmds_channel_encoder_if #(
    parameter int CNT_W = 6
);
    logic                    i_valid;
    logic                    i_de;
    logic [1:0]              i_ctrl;
    logic [7:0]              i_data;
    logic                    o_valid;
    logic [9:0]              o_tmds;
    logic signed [CNT_W-1:0] o_disparity;

    modport master (
        output i_valid, i_de, i_ctrl, i_data,
        input  o_valid, o_tmds, o_disparity
    );

    modport slave (
        input  i_valid, i_de, i_ctrl, i_data,
        output o_valid, o_tmds, o_disparity
    );
endinterface

// File: rtl/tmds_channel_encoder_tm_stage.sv
// Combinational transition-minimisation stage: 8-bit pixel byte to 9-bit q_m.
module tmds_tm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output qm_word_t   qm
);

    logic [3:0] n1;
    logic       use_xnor;
    logic [7:0] chain;

    // XNOR chain is chosen when it yields fewer transitions for dense bytes.
    always_comb begin
        n1       = popcount8(data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
        chain    = '0;
        chain[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ data[i]) : (chain[i-1] ^ data[i]);
        end
        qm = {~use_xnor, chain};
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One TMDS colour channel: registered q_m stage followed by a registered
// DC-balancing / control-token stage with a signed running-disparity counter.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input logic                  i_clk,
    input logic                  i_rst,
    tmds_channel_encoder_if.slave bus
);

    qm_word_t qm_next;

    logic     s1_valid;
    logic     s1_de;
    logic [1:0] s1_ctrl;
    qm_word_t s1_qm;

    logic                    out_valid;
    logic [9:0]              out_tmds;
    logic signed [CNT_W-1:0] cnt;
    period_t                 state;

    logic [3:0]              n1;
    logic                    q8;
    logic signed [CNT_W-1:0] two_n1;
    logic signed [CNT_W-1:0] diff;
    logic signed [CNT_W-1:0] cnt_base;
    logic signed [CNT_W-1:0] cnt_next;
    logic [9:0]              sym_next;

    tmds_tm_stage u_tm_stage (
        .data (bus.i_data),
        .qm   (qm_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_de    <= 1'b0;
            s1_ctrl  <= 2'b00;
            s1_qm    <= '0;
        end else if (bus.i_valid) begin
            s1_valid <= 1'b1;
            s1_de    <= bus.i_de;
            s1_ctrl  <= bus.i_ctrl;
            s1_qm    <= qm_next;
        end
    end

    // diff is N1-N0 = 2*N1-8; a fresh video period always balances from zero.
    always_comb begin
        n1       = popcount8(s1_qm[7:0]);
        q8       = s1_qm[8];
        two_n1   = CNT_W'({n1, 1'b0});
        diff     = two_n1 - CNT_W'(8);
        cnt_base = (state == VIDEO) ? cnt : '0;
        cnt_next = '0;
        sym_next = CTRL_TOKEN_00;
        if (s1_de) begin
            if ((cnt_base == '0) || (n1 == 4'd4)) begin
                sym_next = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
                cnt_next = q8 ? (cnt_base + diff) : (cnt_base - diff);
            end else if ((!cnt_base[CNT_W-1] && (n1 > 4'd4)) ||
                         ( cnt_base[CNT_W-1] && (n1 < 4'd4))) begin
                sym_next = {1'b1, q8, ~s1_qm[7:0]};
                cnt_next = cnt_base - diff + (q8 ? CNT_W'(2) : CNT_W'(0));
            end else begin
                sym_next = {1'b0, q8, s1_qm[7:0]};
                cnt_next = cnt_base + diff - (q8 ? CNT_W'(0) : CNT_W'(2));
            end
        end else begin
            case (s1_ctrl)
                2'b00:   sym_next = CTRL_TOKEN_00;
                2'b01:   sym_next = CTRL_TOKEN_01;
                2'b10:   sym_next = CTRL_TOKEN_10;
                default: sym_next = CTRL_TOKEN_11;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid <= 1'b0;
            out_tmds  <= CTRL_TOKEN_00;
            cnt       <= '0;
            state     <= CTRL;
        end else if (bus.i_valid) begin
            out_valid <= s1_valid;
            out_tmds  <= sym_next;
            cnt       <= cnt_next;
            state     <= s1_de ? VIDEO : CTRL;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // The only even value outside the legal band is the most negative one.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!cnt[0] && (cnt != {1'b1, {(CNT_W-1){1'b0}}}));
        end
    end

    assign bus.o_valid     = out_valid;
    assign bus.o_tmds      = out_tmds;
    assign bus.o_disparity = cnt;

endmodule

// File: doc/tmds_channel_encoder.md
Name: tmds_channel_encoder

Overview:
- Full TMDS encoder for one DVI/HDMI colour channel (blue, green or red).
- Takes 8-bit pixel data plus 2 control bits per pixel clock and emits a 10-bit symbol.
- Stage 1: transition minimisation (q_m). Stage 2: DC balancing via a running-disparity counter, or control-token insertion during blanking.
- Sits between the video timing/pixel source and the 10:1 serialiser. Three instances are used per link.

Parameters:
- CNT_W, default 6: width of the signed running-disparity counter. Must be at least 5.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input symbol qualifier. When low, the pipeline holds and the counter is frozen.
- i_de  in  1  data enable: 1 = video period, 0 = control period.
- i_ctrl  in  2  control bits {C1,C0}. Used only when i_de=0.
- i_data  in  8  pixel byte. Used only when i_de=1.
- o_valid  out  1  o_tmds qualifier.
- o_tmds  out  10  encoded symbol, bit 0 transmitted first.
- o_disparity  out  CNT_W  current running disparity, signed, for debug and verification.

Behaviour:
- Reset: one clock with i_rst high, sampled on the i_clk edge, sets:
  - o_valid=0
  - o_tmds=10'b1101010100 (the ctrl=00 token)
  - o_disparity=0
  - all pipeline registers cleared (de=0, ctrl=00)
- Reset mid-stream discards in-flight symbols. The output returns to the reset values on the next edge.
- Pipeline: two register stages, advanced only when i_valid=1. Latency is exactly 2 accepted symbols, i.e. 2 cycles at continuous i_valid.
- o_valid is the i_valid of the symbol presented at o_tmds, delayed by 2 stages.
- Stage 1 (combinational, then registered with de/ctrl):
  - n1 = popcount(i_data).
  - use_xnor = (n1>4) or (n1==4 and i_data[0]==0).
  - q_m[0] = d[0].
  - For i = 1..7: q_m[i] = q_m[i-1] XOR d[i], inverted when use_xnor.
  - q_m[8] = ~use_xnor.
- Stage 2 definitions: N1 = popcount(q_m[7:0]), N0 = 8-N1, cnt = disparity register.
- Stage 2, de=1 (video):
  - Case A, cnt==0 or N1==N0:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m8 ? (N1-N0) : (N0-N1)
  - Case B, else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m8, ~q_m[7:0]}
    - cnt += 2*q_m8 + (N0-N1)
  - Case C, otherwise:
    - out = {0, q_m8, q_m[7:0]}
    - cnt += (N1-N0) - 2*(~q_m8)
- Stage 2, de=0 (control):
  - ctrl 00 -> 1101010100
  - ctrl 01 -> 0010101011
  - ctrl 10 -> 0101010100
  - ctrl 11 -> 1010101011
  - cnt is forced to 0.
- Period FSM: two states, CTRL and VIDEO, tracking the de of the stage-2 symbol.
  - CTRL->VIDEO: first valid de=1 symbol. cnt starts at 0 for it.
  - VIDEO->CTRL: first valid de=0 symbol. Clears cnt.
- Arithmetic:
  - All disparity maths is signed CNT_W bits. Never saturate.
  - cnt is always even.
  - |cnt| never exceeds 2^(CNT_W-1)-2. Violation is an assertion failure.
- o_disparity shows the counter value after the symbol currently at o_tmds.
- i_valid=0 for any number of cycles: o_tmds, o_disparity and the FSM hold; o_valid=0.
- i_data is ignored in control periods. i_ctrl is ignored in video periods.

Decomposition:
- Shared package tmds_pkg:
  - the four control-token localparams
  - typedef for the 9-bit q_m word
  - enum for the period state (CTRL, VIDEO)
  - popcount8 function
- Sub-module tmds_tm_stage: combinational stage-1 encoder (8-bit in, 9-bit q_m out), instantiated once. Stage 1's output register lives in tmds_channel_encoder.

Test Plan:
- Reset then i_de=0, ctrl=01, continuous valid -> o_tmds=10'b0010101011 from the 2nd accepted symbol. o_disparity=0 throughout. o_valid low until the 2nd cycle after reset.
- i_de=1, data 0x00 twice from cnt=0 -> outputs 0x100 (cnt=-8), then 0x3FF (cnt=+2).
- i_de=1, data 0xFF from cnt=0 -> q_m=0x0FF, o_tmds=0x200, cnt=-8.
- Alternating video bursts of 0x00 and 0x10 with mid-burst i_valid gaps of 3 cycles -> outputs match a golden DVI model, cnt stays even, |cnt|<=30, and outputs hold during gaps.
- Video burst leaving cnt≠0, then de=0 ctrl=10 -> o_tmds=0101010100 and cnt=0. The next video symbol 0x00 encodes as 0x100 (Case A).
- i_rst asserted for one cycle mid-burst -> next edge gives o_valid=0, o_tmds=1101010100, cnt=0. Symbols in flight are not emitted.
